// File: rtl/window_scan_ctrl_pkg.sv
// window_scan_pkg: shared state encoding and widths for window_scan_ctrl.
// BORDER exists only when WINDOW_SCAN_BORDER_EN is defined.
package window_scan_pkg;
   localparam int AW = 8;
   localparam int PW = 8;
   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      DRAIN,
`ifdef WINDOW_SCAN_BORDER_EN
      BORDER,
`endif
      FIN
   } state_t;
endpackage

// File: rtl/window_scan_ctrl_if.sv
// window_scan_ctrl_if: start/filter-result inputs and memory read/write strobes of the scan controller.
interface window_scan_ctrl_if;
   import window_scan_pkg::*;
   logic start, res_valid, rd, wr, busy, done, err;
   logic [PW-1:0] res_pixel, cl_pixel;
   logic [AW-1:0] addr_row_r, addr_col_r, addr_row_w, addr_col_w;
   modport master (
      input  start, res_valid, res_pixel,
      output rd, addr_row_r, addr_col_r, wr, addr_row_w, addr_col_w, cl_pixel, busy, done, err
   );
   modport slave (
      output start, res_valid, res_pixel,
      input  rd, addr_row_r, addr_col_r, wr, addr_row_w, addr_col_w, cl_pixel, busy, done, err
   );
endinterface

// File: rtl/window_scan_ctrl_res_fifo.sv
// scan_res_fifo: small result queue; a push on a full queue is taken when a pop frees a slot that cycle.
module scan_res_fifo #(
   parameter int DEPTH = 2,
   parameter int W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PTR = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [W-1:0] mem [DEPTH];
   logic [PTR-1:0] rp, wp;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = mem[rp];
   always_ff @(posedge clk) begin
      if (!rst) begin
         {rp, wp, count} <= '0;
      end else begin
         if (do_push) begin
            mem[wp] <= din;
            wp <= wp == PTR'(DEPTH - 1) ? '0 : wp + 1'b1;
         end
         if (do_pop) rp <= rp == PTR'(DEPTH - 1) ? '0 : rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: raster window-origin scanner with credit-limited reads and in-order result write-back.
// Defining WINDOW_SCAN_BORDER_EN adds a pass that writes 0 to the border pixels after the scan.
module window_scan_ctrl
   import window_scan_pkg::*;
#(
   parameter int IMG_H = 256,
   parameter int IMG_W = 256,
   parameter int CREDITS = 2
) (
   input logic clk,
   input logic rst,
   window_scan_ctrl_if.master bus
);
   localparam int CW = $clog2(CREDITS + 1);
   localparam logic [AW-1:0] RMAX = AW'(IMG_H - 3);
   localparam logic [AW-1:0] CMAX = AW'(IMG_W - 3);
   localparam bit HAS_ORG = IMG_H > 2 && IMG_W > 2;
   state_t state, state_n;
   logic [AW-1:0] rrow, rcol, wrow, wcol;
   logic [CW-1:0] outst, qcnt;
   logic [PW-1:0] q_dout;
   logic rem, issue, pop, accept, q_full, q_empty, last_r, last_w, bwr;
`ifdef WINDOW_SCAN_BORDER_EN
   localparam state_t POST_DRAIN = BORDER;
   localparam logic [AW-1:0] BCOL = AW'(IMG_W - 2);
   localparam logic [AW-1:0] BCOL0 = IMG_H > 2 ? BCOL : '0;
   logic [AW-1:0] brow, bcol;
   logic b_last;
   assign b_last = brow == AW'(IMG_H - 1) && bcol == AW'(IMG_W - 1);
   assign bwr = state == BORDER;
`else
   localparam state_t POST_DRAIN = FIN;
   assign bwr = 1'b0;
`endif
   // Draining queued results always wins over issuing a new read
   assign pop = !q_empty;
   assign last_r = rrow == RMAX && rcol == CMAX;
   assign last_w = wrow == RMAX && wcol == CMAX;
   assign issue = state == SCAN && q_empty && rem && outst + qcnt < CW'(CREDITS);
   assign accept = bus.res_valid && outst != '0 && (!q_full || pop);
   scan_res_fifo #(.DEPTH(CREDITS), .W(PW)) u_fifo (
      .clk(clk), .rst(rst), .push(accept), .pop(pop), .din(bus.res_pixel),
      .dout(q_dout), .count(qcnt), .full(q_full), .empty(q_empty)
   );
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = bus.start ? SCAN : IDLE;
         SCAN:    state_n = (!rem || (issue && last_r)) ? DRAIN : SCAN;
         DRAIN:   state_n = (outst == '0 && q_empty) ? POST_DRAIN : DRAIN;
`ifdef WINDOW_SCAN_BORDER_EN
         BORDER:  state_n = b_last ? FIN : BORDER;
`endif
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         {rrow, rcol, wrow, wcol, outst, rem} <= '0;
         {bus.rd, bus.wr, bus.busy, bus.done, bus.err} <= '0;
         {bus.addr_row_r, bus.addr_col_r, bus.addr_row_w, bus.addr_col_w, bus.cl_pixel} <= '0;
`ifdef WINDOW_SCAN_BORDER_EN
         {brow, bcol} <= '0;
`endif
      end else begin
         state <= state_n;
         bus.rd <= issue;
         bus.wr <= pop || bwr;
         bus.busy <= state_n != IDLE;
         bus.done <= state == FIN;
         outst <= outst + CW'(issue) - CW'(accept);
         if (bus.res_valid && !accept) bus.err <= 1'b1;
         if (state == IDLE && bus.start) begin
            {rrow, rcol, wrow, wcol} <= '0;
            rem <= HAS_ORG;
         end
         if (issue) begin
            bus.addr_row_r <= rrow;
            bus.addr_col_r <= rcol;
            rem <= !last_r;
            if (!last_r) begin
               rcol <= rcol == CMAX ? '0 : rcol + 1'b1;
               rrow <= rcol == CMAX ? rrow + 1'b1 : rrow;
            end
         end
         if (pop) begin
            bus.addr_row_w <= wrow;
            bus.addr_col_w <= wcol;
            bus.cl_pixel <= q_dout;
            if (!last_w) begin
               wcol <= wcol == CMAX ? '0 : wcol + 1'b1;
               wrow <= wcol == CMAX ? wrow + 1'b1 : wrow;
            end
         end
`ifdef WINDOW_SCAN_BORDER_EN
         // Interior rows only carry the two rightmost columns; skip straight to them
         if (state == DRAIN) begin
            brow <= '0;
            bcol <= BCOL0;
         end
         if (bwr) begin
            bus.addr_row_w <= brow;
            bus.addr_col_w <= bcol;
            bus.cl_pixel <= '0;
            if (!b_last) begin
               bcol <= bcol == AW'(IMG_W - 1) ? (int'(brow) + 3 < IMG_H ? BCOL : '0) : bcol + 1'b1;
               brow <= bcol == AW'(IMG_W - 1) ? brow + 1'b1 : brow;
            end
         end
`endif
      end
   end
endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb_window_scan_ctrl: randomized self-checking bench; a 4x4 instance covers scan, credits, errors and border,
// a default 256x256 instance covers reset in the middle of a scan.
module tb_window_scan_ctrl;
   import window_scan_pkg::*;
   localparam int H = 4, W = 4, CR = 2, NORG = (H - 2) * (W - 2);
`ifdef WINDOW_SCAN_BORDER_EN
   localparam int NBRD = H * W - NORG;
`else
   localparam int NBRD = 0;
`endif
   logic clk = 1'b0, rst = 1'b0;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   window_scan_ctrl_if s_if();
   window_scan_ctrl_if l_if();
   window_scan_ctrl #(.IMG_H(H), .IMG_W(W), .CREDITS(CR)) dut_s (.clk(clk), .rst(rst), .bus(s_if));
   window_scan_ctrl dut_l (.clk(clk), .rst(rst), .bus(l_if));

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({s_if.rd, s_if.wr, s_if.busy, s_if.done, s_if.err, l_if.rd, l_if.wr, l_if.busy, l_if.done, l_if.err} !== 10'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0", {s_if.rd, s_if.wr, s_if.busy, s_if.done, s_if.err, l_if.rd, l_if.wr, l_if.busy, l_if.done, l_if.err});
      end
      checks++;
      if ({s_if.addr_row_r, s_if.addr_col_r, s_if.addr_row_w, s_if.addr_col_w, s_if.cl_pixel} !== 40'b0) begin
         errors++;
         $display("FAIL reset_addr: got %h want 0", {s_if.addr_row_r, s_if.addr_col_r, s_if.addr_row_w, s_if.addr_col_w, s_if.cl_pixel});
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   // mode 0: fixed latency 2, data A0+n; mode 1: random latency/data plus a stray start; mode 2: first reads stall 10 cycles
   task automatic test_scan(input int mode);
      int due_q[$], exp_r[$], exp_c[$], exp_d[$], br[$], bc[$];
      int cyc = 0, nrd = 0, nwr = 0, nres = 0, ndone = 0, rd_pre = 0, last_due = 0, lat, d, er, ec, ed;
      bit got_res = 0;
      logic [7:0] pix;
`ifdef WINDOW_SCAN_BORDER_EN
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if (r >= H - 2 || c >= W - 2) begin
               br.push_back(r);
               bc.push_back(c);
            end
`endif
      s_if.start = 1'b1;
      @(negedge clk);
      s_if.start = 1'b0;
      checks++;
      if (s_if.busy !== 1'b1) begin errors++; $display("FAIL busy_after_start m%0d: got %b want 1", mode, s_if.busy); end
      while (ndone == 0 && cyc < 500) begin
         s_if.res_valid = 1'b0;
         s_if.start = mode == 1 && cyc == 3;
         if (s_if.rd) begin
            checks++;
            if (s_if.addr_row_r !== 8'(nrd / (W - 2)) || s_if.addr_col_r !== 8'(nrd % (W - 2))) begin
               errors++;
               $display("FAIL rd_origin m%0d #%0d: got (%0d,%0d) want (%0d,%0d)", mode, nrd, s_if.addr_row_r, s_if.addr_col_r, nrd / (W - 2), nrd % (W - 2));
            end
            lat = mode == 0 ? 2 : (mode == 2 && nrd < CR) ? 10 : int'($urandom_range(1, 5));
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            due_q.push_back(d);
            last_due = d;
            nrd++;
         end
         if (s_if.wr) begin
            checks++;
            if (exp_r.size() > 0) begin
               er = exp_r.pop_front(); ec = exp_c.pop_front(); ed = exp_d.pop_front();
            end else if (br.size() > 0) begin
               er = br.pop_front(); ec = bc.pop_front(); ed = 0;
            end else begin
               er = -1; ec = -1; ed = -1;
            end
            if (er < 0 || s_if.addr_row_w !== 8'(er) || s_if.addr_col_w !== 8'(ec) || s_if.cl_pixel !== 8'(ed)) begin
               errors++;
               $display("FAIL wr m%0d #%0d: got (%0d,%0d)=%h want (%0d,%0d)=%h", mode, nwr, s_if.addr_row_w, s_if.addr_col_w, s_if.cl_pixel, er, ec, ed);
            end
            nwr++;
         end
         checks++;
         if ((s_if.rd && s_if.wr) || nrd - nwr > CR) begin
            errors++;
            $display("FAIL rd_wr_credit m%0d cyc %0d: rd=%b wr=%b in_flight=%0d want exclusive and <=%0d", mode, cyc, s_if.rd, s_if.wr, nrd - nwr, CR);
         end
         if (s_if.done) begin
            ndone++;
            checks++;
            if (s_if.busy !== 1'b0) begin errors++; $display("FAIL busy_at_done m%0d: got %b want 0", mode, s_if.busy); end
         end
         if (!got_res) rd_pre = nrd;
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            pix = mode == 0 ? 8'(8'hA0 + nres) : 8'($urandom);
            s_if.res_valid = 1'b1;
            s_if.res_pixel = pix;
            exp_r.push_back(nres / (W - 2));
            exp_c.push_back(nres % (W - 2));
            exp_d.push_back(int'(pix));
            nres++;
            got_res = 1;
         end
         @(negedge clk);
         cyc++;
      end
      s_if.res_valid = 1'b0;
      s_if.start = 1'b0;
      checks++;
      if (ndone != 1) begin errors++; $display("FAIL done_seen m%0d: got %0d want 1 within 500 cycles", mode, ndone); end
      checks++;
      if (nrd != NORG || nwr != NORG + NBRD) begin
         errors++;
         $display("FAIL counts m%0d: got rd=%0d wr=%0d want rd=%0d wr=%0d", mode, nrd, nwr, NORG, NORG + NBRD);
      end
      if (mode == 2) begin
         checks++;
         if (rd_pre != CR) begin errors++; $display("FAIL stall_reads: got %0d want %0d", rd_pre, CR); end
      end
      repeat (3) begin
         checks++;
         if ({s_if.rd, s_if.wr, s_if.busy, s_if.done, s_if.err} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after m%0d: rd,wr,busy,done,err got %b want 0", mode, {s_if.rd, s_if.wr, s_if.busy, s_if.done, s_if.err});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_err_drop();
      int nwr = 0;
      s_if.res_valid = 1'b1;
      s_if.res_pixel = 8'h55;
      @(negedge clk);
      s_if.res_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (s_if.wr) nwr++;
      end
      checks++;
      if (s_if.err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", s_if.err); end
      checks++;
      if (nwr != 0) begin errors++; $display("FAIL err_dropped: got %0d writes want 0", nwr); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (s_if.err !== 1'b0) begin errors++; $display("FAIL err_reset: got %b want 0", s_if.err); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_scan();
      int nrd = 0;
      bit hit = 0;
      l_if.start = 1'b1;
      @(negedge clk);
      l_if.start = 1'b0;
      for (int i = 0; i < 60; i++) begin
         l_if.res_valid = l_if.rd;
         l_if.res_pixel = 8'(i);
         if (l_if.rd) begin
            checks++;
            if (l_if.addr_row_r !== 8'(nrd / 254) || l_if.addr_col_r !== 8'(nrd % 254)) begin
               errors++;
               $display("FAIL big_origin #%0d: got (%0d,%0d) want (%0d,%0d)", nrd, l_if.addr_row_r, l_if.addr_col_r, nrd / 254, nrd % 254);
            end
            nrd++;
         end
         @(negedge clk);
      end
      checks++;
      if (nrd < 10) begin errors++; $display("FAIL big_progress: got %0d reads want >=10", nrd); end
      l_if.res_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({l_if.rd, l_if.wr, l_if.busy} !== 3'b0 || dut_l.state !== IDLE) begin
         errors++;
         $display("FAIL mid_reset: rd,wr,busy got %b state %0d want 0 and IDLE", {l_if.rd, l_if.wr, l_if.busy}, dut_l.state);
      end
      rst = 1'b1;
      @(negedge clk);
      l_if.start = 1'b1;
      @(negedge clk);
      l_if.start = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         if (l_if.rd) begin
            hit = 1;
            checks++;
            if (l_if.addr_row_r !== 8'd0 || l_if.addr_col_r !== 8'd0) begin
               errors++;
               $display("FAIL rescan_origin: got (%0d,%0d) want (0,0)", l_if.addr_row_r, l_if.addr_col_r);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL rescan_rd: got no rd in 10 cycles want one"); end
      checks++;
      if (l_if.err !== 1'b0) begin errors++; $display("FAIL rescan_err: got %b want 0", l_if.err); end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      {s_if.start, s_if.res_valid, l_if.start, l_if.res_valid} = 4'b0;
      s_if.res_pixel = 8'h00;
      l_if.res_pixel = 8'h00;
      test_reset();
      test_scan(0);
      test_scan(2);
      repeat (5) test_scan(1);
      test_err_drop();
      test_reset_mid_scan();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
